// File: rtl/fifo_cmd_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_cmd_parser: drains one framed command packet from the RX FIFO and     |
// | validates it. Optional stall timeout with FIFOC_TIMEOUT_EN. Rev 1.0        |
// +----------------------------------------------------------------------------+
module fifo_cmd_parser #(
  parameter int          NUM_CMD     = 9,
  parameter int          MAX_LEN     = 32,
  parameter logic [15:0] HDR         = 16'h55AA,
  parameter int          LEN_W       = 12,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fs,
  output logic                   fd,
  input  logic [LEN_W-1:0]       data_len,
  output logic                   fifo_rxen,
  input  logic [7:0]             fifo_rxd,
  input  logic                   fifo_empty,
  output logic [8*NUM_CMD-1:0]   cmd_data,
  output logic                   cmd_vld,
  output logic                   err,
  output logic [1:0]             err_code
);

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(NUM_CMD + 3);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [1:0] CODE_OK  = 2'b00;
  localparam logic [1:0] CODE_HDR = 2'b01;
  localparam logic [1:0] CODE_CKS = 2'b10;
  localparam logic [1:0] CODE_LEN = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  logic [LEN_W-1:0]     frame_len;
  logic [LEN_W-1:0]     rd_cnt;
  logic [LEN_W-1:0]     rx_cnt;
  logic                 rx_vld;
  logic                 len_err;
  logic                 hdr_err;
  logic [7:0]           sum;
  logic [7:0]           cks;
  logic [8*NUM_CMD-1:0] shadow;
  logic                 timeout;

  assign fifo_rxen = (state == READ) && !fifo_empty && (rd_cnt < frame_len);
  assign fd        = (state == DONE);

`ifdef FIFOC_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_cnt;

  // Any captured byte proves the FIFO is still feeding us, so it restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (state != READ || rx_vld)
      stall_cnt <= '0;
    else if (fifo_empty)
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign timeout = (state == READ) && !rx_vld && fifo_empty &&
                   (stall_cnt == STALL_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      frame_len <= '0;
      rd_cnt    <= '0;
      rx_cnt    <= '0;
      rx_vld    <= 1'b0;
      len_err   <= 1'b0;
      hdr_err   <= 1'b0;
      sum       <= '0;
      cks       <= '0;
      shadow    <= '0;
      cmd_data  <= '0;
      cmd_vld   <= 1'b0;
      err       <= 1'b0;
      err_code  <= CODE_OK;
    end else begin
      cmd_vld <= 1'b0;
      rx_vld  <= fifo_rxen;
      case (state)
        IDLE: begin
          if (fs) begin
            frame_len <= data_len;
            rd_cnt    <= '0;
            rx_cnt    <= '0;
            hdr_err   <= 1'b0;
            sum       <= '0;
            if (data_len >= MIN_L && data_len <= MAX_L) begin
              len_err <= 1'b0;
              state   <= READ;
            end else begin
              len_err <= 1'b1;
              state   <= CHECK;
            end
          end
        end
        READ: begin
          if (fifo_rxen)
            rd_cnt <= rd_cnt + 1'b1;
          if (rx_vld) begin
            rx_cnt <= rx_cnt + 1'b1;
            if (rx_cnt == '0 && fifo_rxd != HDR[15:8])
              hdr_err <= 1'b1;
            if (rx_cnt == LEN_W'(1) && fifo_rxd != HDR[7:0])
              hdr_err <= 1'b1;
            if (rx_cnt >= LEN_W'(2) && rx_cnt < frame_len - 1'b1)
              sum <= sum + fifo_rxd;
            // First payload byte lands in the most significant byte of the bus.
            for (int i = 0; i < NUM_CMD; i++)
              if (rx_cnt == LEN_W'(i + 2))
                shadow[8*(NUM_CMD-1-i) +: 8] <= fifo_rxd;
            if (rx_cnt == frame_len - 1'b1) begin
              cks   <= fifo_rxd;
              state <= CHECK;
            end
          end
          if (timeout) begin
            len_err <= 1'b1;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (len_err || hdr_err || sum != cks) begin
            cmd_data <= '1;
            err      <= 1'b1;
            err_code <= len_err ? CODE_LEN : (hdr_err ? CODE_HDR : CODE_CKS);
          end else begin
            cmd_data <= shadow;
            cmd_vld  <= 1'b1;
            err      <= 1'b0;
            err_code <= CODE_OK;
          end
          state <= DONE;
        end
        DONE: begin
          if (!fs)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_cmd_parser.sv
`default_nettype none
// Testbench for fifo_cmd_parser: FIFO model, frame-level expected-result model,
// per-cycle output comparison against that model.
module tb_fifo_cmd_parser;

  localparam int NUM_CMD = 9;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 12;
  localparam int TO_CYC  = 4;
  localparam int W       = 8 * NUM_CMD;

  logic             clk;
  logic             rst;
  logic             fs;
  logic             fd;
  logic [LEN_W-1:0] data_len;
  logic             fifo_rxen;
  logic [7:0]       fifo_rxd;
  logic             fifo_empty;
  logic [W-1:0]     cmd_data;
  logic             cmd_vld;
  logic             err;
  logic [1:0]       err_code;

  fifo_cmd_parser #(
    .NUM_CMD(NUM_CMD), .MAX_LEN(MAX_LEN), .HDR(16'h55AA),
    .LEN_W(LEN_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd), .data_len(data_len),
    .fifo_rxen(fifo_rxen), .fifo_rxd(fifo_rxd), .fifo_empty(fifo_empty),
    .cmd_data(cmd_data), .cmd_vld(cmd_vld), .err(err), .err_code(err_code)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic         exp_fd, exp_vld, exp_err;
  logic [1:0]   exp_code;
  logic [W-1:0] exp_cmd;

  logic [7:0] frm[$];
  logic [7:0] q[$];
  int         reads       = 0;
  int         stall_after = 0;
  int         stall_left  = 0;
  int         last_done   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, expv, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO: registered read data, one cycle after the sampled read enable.
  initial begin
    logic rd_s;
    fifo_rxd   = 8'h00;
    fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      rd_s = fifo_rxen;
      @(posedge clk);
      #2;
      if (rd_s) begin
        check("fifo_underflow", W'(q.size() == 0), '0);
        if (q.size() > 0) fifo_rxd = q.pop_front();
        reads++;
      end
      if (stall_left > 0 && reads >= stall_after) begin
        fifo_empty = 1'b1;
        stall_left--;
      end else begin
        fifo_empty = (q.size() == 0);
      end
    end
  end

  always @(negedge clk) begin
    check("fd", W'(fd), W'(exp_fd));
    check("cmd_vld", W'(cmd_vld), W'(exp_vld));
    check("cmd_data", cmd_data, exp_cmd);
    check("err", W'(err), W'(exp_err));
    check("err_code", W'(err_code), W'(exp_code));
  end

  function automatic logic [7:0] payload_sum(input int len);
    logic [7:0] s = 8'h00;
    for (int i = 2; i <= len - 2; i++) s = s + frm[i];
    return s;
  endfunction

  task automatic build_frame(input logic [7:0] h1, input logic [7:0] base,
                             input int npay, input logic [7:0] cks);
    frm.delete();
    frm.push_back(8'h55);
    frm.push_back(h1);
    for (int i = 0; i < npay; i++) frm.push_back(base + 8'(i));
    frm.push_back(cks);
  endtask

  // Called at #1 into an idle cycle; that cycle is cycle 0 of the frame.
  task automatic run_frame(input int len, input int st_after, input int st_len, input int hold);
    int           done, e_reads;
    logic [1:0]   e_code;
    logic [W-1:0] e_data;
    if (len < NUM_CMD + 3 || len > MAX_LEN) begin
      e_code  = 2'b11;
      done    = 2;
      e_reads = 0;
    end else begin
      e_reads = len;
      done    = len + 3 + st_len;
      if (frm[0] != 8'h55 || frm[1] != 8'hAA) e_code = 2'b01;
      else if (payload_sum(len) != frm[len-1]) e_code = 2'b10;
      else e_code = 2'b00;
`ifdef FIFOC_TIMEOUT_EN
      if (st_len >= TO_CYC) begin
        e_code  = 2'b11;
        done    = st_after + 3 + TO_CYC;
        e_reads = st_after;
      end
`endif
    end
    e_data = '1;
    if (e_code == 2'b00)
      for (int i = 0; i < NUM_CMD; i++) e_data[W-1-8*i -: 8] = frm[2+i];
    last_done   = done;
    q           = frm;
    reads       = 0;
    stall_after = st_after;
    stall_left  = st_len;
    data_len    = LEN_W'(len);
    fs          = 1'b1;
    for (int c = 1; c <= done + hold + 1; c++) begin
      @(posedge clk);
      #1;
      if (c == done) begin
        exp_fd   = 1'b1;
        exp_vld  = (e_code == 2'b00);
        exp_cmd  = e_data;
        exp_err  = (e_code != 2'b00);
        exp_code = e_code;
      end
      if (c == done + 1) exp_vld = 1'b0;
      if (c == done + hold) fs = 1'b0;
      if (c == done + hold + 1) exp_fd = 1'b0;
    end
    check("fifo_reads", W'(reads), W'(e_reads));
    q.delete();
    stall_left = 0;
  endtask

  task automatic set_reset_exp();
    exp_fd   = 1'b0;
    exp_vld  = 1'b0;
    exp_err  = 1'b0;
    exp_code = 2'b00;
    exp_cmd  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end by t=200000");
    $fatal(1, "watchdog");
  end

  initial begin
    set_reset_exp();
    rst      = 1'b1;
    fs       = 1'b0;
    data_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fd", W'(fd), '0);
    check("rst_rxen", W'(fifo_rxen), '0);
    check("rst_cmd", cmd_data, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Good 12-byte frame, fs held two cycles into DONE
    build_frame(8'hAA, 8'h01, 9, 8'h2D);
    check("lit_model_sum", W'(payload_sum(12)), W'(8'h2D));
    run_frame(12, 0, 0, 2);
    check("lit_good_cmd", cmd_data, 72'h010203040506070809);
    check("lit_good_done", W'(last_done), W'(15));
    check("lit_good_err", W'(err), '0);

    // Bad checksum
    build_frame(8'hAA, 8'h01, 9, 8'h2E);
    run_frame(12, 0, 0, 0);
    check("lit_cks_code", W'(err_code), W'(2'b10));
    check("lit_cks_cmd", cmd_data, {W{1'b1}});

    // Good frame clears the error
    build_frame(8'hAA, 8'h01, 9, 8'h2D);
    run_frame(12, 0, 0, 0);
    check("lit_clear_err", W'(err), '0);

    // Bad header, still all bytes read
    build_frame(8'hAB, 8'h01, 9, 8'h2D);
    run_frame(12, 0, 0, 0);
    check("lit_hdr_code", W'(err_code), W'(2'b01));

    // Length errors below and above the legal range
    build_frame(8'hAA, 8'h01, 9, 8'h2D);
    run_frame(11, 0, 0, 0);
    check("lit_short_code", W'(err_code), W'(2'b11));
    build_frame(8'hAA, 8'h01, 9, 8'h2D);
    run_frame(33, 0, 0, 1);
    check("lit_long_done", W'(last_done), W'(2));

    // Five empty cycles after byte 6
    build_frame(8'hAA, 8'h01, 9, 8'h2D);
    run_frame(12, 7, 5, 0);
`ifdef FIFOC_TIMEOUT_EN
    check("lit_stall_done", W'(last_done), W'(14));
    check("lit_stall_code", W'(err_code), W'(2'b11));
`else
    check("lit_stall_done", W'(last_done), W'(20));
    check("lit_stall_cmd", cmd_data, 72'h010203040506070809);
`endif

    // Payload longer than NUM_CMD: extra bytes only feed the checksum
    build_frame(8'hAA, 8'h10, 11, 8'hE7);
    run_frame(14, 0, 0, 0);
    check("lit_long_pay_cmd", cmd_data, 72'h101112131415161718);

    // Maximum length frame
    build_frame(8'hAA, 8'h01, 29, 8'hB3);
    check("lit_max_sum", W'(payload_sum(32)), W'(8'hB3));
    run_frame(32, 0, 0, 0);
    check("lit_max_err", W'(err), '0);

    // Reset in cycle 6 of a frame
    build_frame(8'hAA, 8'h01, 9, 8'h2E);
    q        = frm;
    reads    = 0;
    data_len = LEN_W'(12);
    fs       = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    set_reset_exp();
    #1;
    check("mid_rst_cmd", cmd_data, '0);
    check("mid_rst_err", W'(err), '0);
    check("mid_rst_code", W'(err_code), '0);
    check("mid_rst_fd", W'(fd), '0);
    check("mid_rst_rxen", W'(fifo_rxen), '0);
    check("mid_rst_reads", W'(reads), W'(5));
    fs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    rst = 1'b0;
    build_frame(8'hAA, 8'h01, 9, 8'h2D);
    run_frame(12, 0, 0, 0);
    check("lit_after_rst_cmd", cmd_data, 72'h010203040506070809);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
